// File: rtl/instr_sequencer.sv
// Program sequencer for the processor core: buffers instruction words while idle,
// then issues them one at a time, advancing on each core completion pulse.
module instr_sequencer #(
   parameter int DEPTH   = 16,
   parameter int AW      = 4,
   parameter int TIMEOUT = 8
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          wr_en,
   input  logic [15:0]   wr_data,
   input  logic          start,
   input  logic          clear,
   input  logic          proc_done,
   input  logic [15:0]   proc_out,
   output logic [15:0]   iin,
   output logic          iin_valid,
   output logic          proc_resetn,
   output logic [AW-1:0] pc,
   output logic [AW:0]   count,
   output logic [15:0]   last_result,
   output logic          busy,
   output logic          halted,
   output logic          error,
   output logic          full
);

   localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

   localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
   localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
   localparam logic [AW-1:0] PC_ONE   = AW'(1);
   localparam logic [TW-1:0] T_LAST   = TW'(TIMEOUT - 1);
   localparam logic [TW-1:0] T_ONE    = TW'(1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_WAIT,
      S_HALT,
      S_ERROR
   } state_t;

   state_t state, state_nxt;

   logic [15:0]   mem [DEPTH];
   logic [TW-1:0] timer, timer_nxt;
   logic [AW-1:0] pc_nxt;
   logic [AW:0]   count_nxt;
   logic [15:0]   iin_nxt;
   logic [15:0]   last_result_nxt;
   logic          mem_we;

   logic [AW-1:0] pc_inc;
   logic [AW:0]   last_idx;

   assign pc_inc   = pc + PC_ONE;
   assign last_idx = count - CNT_ONE;
   assign full     = (count == CNT_FULL);

   // Next-state and next-register logic; priority is clear > start > everything else.
   always_comb begin
      state_nxt       = state;
      pc_nxt          = pc;
      count_nxt       = count;
      iin_nxt         = iin;
      last_result_nxt = last_result;
      timer_nxt       = timer;
      mem_we          = 1'b0;

      if (clear) begin
         state_nxt = S_IDLE;
         count_nxt = '0;
         pc_nxt    = '0;
      end else if (start && (state != S_WAIT)) begin
         if (count == '0) begin
            state_nxt = S_HALT;
         end else begin
            state_nxt = S_WAIT;
            pc_nxt    = '0;
            iin_nxt   = mem[0];
            timer_nxt = '0;
         end
      end else if (state == S_WAIT) begin
         if (proc_done) begin
            last_result_nxt = proc_out;
            if ({1'b0, pc} == last_idx) begin
               state_nxt = S_HALT;
            end else begin
               pc_nxt    = pc_inc;
               iin_nxt   = mem[pc_inc];
               timer_nxt = '0;
            end
         end else if (timer == T_LAST) begin
            state_nxt = S_ERROR;
         end else begin
            timer_nxt = timer + T_ONE;
         end
      end else if ((state == S_IDLE) && wr_en && (count != CNT_FULL)) begin
         mem_we    = 1'b1;
         count_nxt = count + CNT_ONE;
      end
   end

   // Status outputs are registered copies of the next-state decode.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= S_IDLE;
         pc          <= '0;
         count       <= '0;
         iin         <= '0;
         last_result <= '0;
         timer       <= '0;
         iin_valid   <= 1'b0;
         proc_resetn <= 1'b0;
         busy        <= 1'b0;
         halted      <= 1'b0;
         error       <= 1'b0;
      end else begin
         state       <= state_nxt;
         pc          <= pc_nxt;
         count       <= count_nxt;
         iin         <= iin_nxt;
         last_result <= last_result_nxt;
         timer       <= timer_nxt;
         iin_valid   <= (state_nxt == S_WAIT);
         proc_resetn <= (state_nxt == S_WAIT);
         busy        <= (state_nxt == S_WAIT);
         halted      <= (state_nxt == S_HALT);
         error       <= (state_nxt == S_ERROR);
      end
   end

   // Program storage carries no reset; contents are only meaningful below count.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[count[AW-1:0]] <= wr_data;
      end
   end

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed bench for instr_sequencer: load, run, timeout, overflow, priority, async reset.
module tb_instr_sequencer;

   localparam int DEPTH   = 16;
   localparam int AW      = 4;
   localparam int TIMEOUT = 8;

   logic          clk = 1'b0;
   logic          resetn;
   logic          wr_en;
   logic [15:0]   wr_data;
   logic          start;
   logic          clear;
   logic          proc_done;
   logic [15:0]   proc_out;
   logic [15:0]   iin;
   logic          iin_valid;
   logic          proc_resetn;
   logic [AW-1:0] pc;
   logic [AW:0]   count;
   logic [15:0]   last_result;
   logic          busy;
   logic          halted;
   logic          error;
   logic          full;

   int n_chk = 0;
   int n_err = 0;

   instr_sequencer #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
      .clk         (clk),
      .resetn      (resetn),
      .wr_en       (wr_en),
      .wr_data     (wr_data),
      .start       (start),
      .clear       (clear),
      .proc_done   (proc_done),
      .proc_out    (proc_out),
      .iin         (iin),
      .iin_valid   (iin_valid),
      .proc_resetn (proc_resetn),
      .pc          (pc),
      .count       (count),
      .last_result (last_result),
      .busy        (busy),
      .halted      (halted),
      .error       (error),
      .full        (full)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic write_word(input logic [15:0] d);
      wr_en   = 1'b1;
      wr_data = d;
      step();
      wr_en   = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic pulse_clear();
      clear = 1'b1;
      step();
      clear = 1'b0;
   endtask

   task automatic done_pulse(input logic [15:0] r);
      proc_done = 1'b1;
      proc_out  = r;
      step();
      proc_done = 1'b0;
   endtask

   initial begin
      resetn    = 1'b0;
      wr_en     = 1'b0;
      wr_data   = '0;
      start     = 1'b0;
      clear     = 1'b0;
      proc_done = 1'b0;
      proc_out  = '0;
      step();
      step();

      // reset state
      chk("rst_iin",       iin, 32'h0);
      chk("rst_count",     count, 32'd0);
      chk("rst_pc",        pc, 32'd0);
      chk("rst_last",      last_result, 32'h0);
      chk("rst_flags",     {iin_valid, busy, halted, error, proc_resetn}, 32'b0);
      resetn = 1'b1;
      step();

      // load three words
      write_word(16'h2080);
      write_word(16'h4100);
      write_word(16'h0000);
      chk("load_count",    count, 32'd3);
      chk("load_valid",    iin_valid, 32'd0);
      chk("load_presetn",  proc_resetn, 32'd0);
      chk("load_full",     full, 32'd0);

      // normal run: done 3 cycles after each issue
      pulse_start();
      chk("run0_iin",      iin, 32'h2080);
      chk("run0_valid",    iin_valid, 32'd1);
      chk("run0_presetn",  proc_resetn, 32'd1);
      chk("run0_busy",     busy, 32'd1);
      step();
      step();
      done_pulse(16'd5);
      chk("run1_iin",      iin, 32'h4100);
      chk("run1_pc",       pc, 32'd1);
      chk("run1_last",     last_result, 32'd5);
      step();
      step();
      done_pulse(16'd9);
      chk("run2_iin",      iin, 32'h0000);
      chk("run2_pc",       pc, 32'd2);
      chk("run2_last",     last_result, 32'd9);
      step();
      step();
      done_pulse(16'd14);
      chk("end_halted",    halted, 32'd1);
      chk("end_last",      last_result, 32'd14);
      chk("end_pc",        pc, 32'd2);
      chk("end_presetn",   proc_resetn, 32'd0);
      chk("end_valid",     iin_valid, 32'd0);
      chk("end_busy",      busy, 32'd0);

      // timeout: error exactly TIMEOUT cycles after iin_valid rises
      pulse_start();
      chk("to_valid",      iin_valid, 32'd1);
      chk("to_halt_clr",   halted, 32'd0);
      for (int i = 0; i < TIMEOUT - 1; i++) step();
      chk("to_early",      error, 32'd0);
      step();
      chk("to_error",      error, 32'd1);
      chk("to_pc",         pc, 32'd0);
      chk("to_valid0",     iin_valid, 32'd0);
      chk("to_presetn",    proc_resetn, 32'd0);
      done_pulse(16'h0063);
      chk("stray_done",    last_result, 32'd14);
      pulse_start();
      chk("re_error",      error, 32'd0);
      chk("re_iin",        iin, 32'h2080);
      chk("re_valid",      iin_valid, 32'd1);

      // done coinciding with the timeout cycle advances instead of erroring
      for (int i = 0; i < TIMEOUT - 1; i++) step();
      done_pulse(16'h0033);
      chk("tie_error",     error, 32'd0);
      chk("tie_pc",        pc, 32'd1);
      chk("tie_iin",       iin, 32'h4100);
      chk("tie_last",      last_result, 32'h0033);

      // clear during WAIT
      pulse_clear();
      chk("clr_busy",      busy, 32'd0);
      chk("clr_valid",     iin_valid, 32'd0);
      chk("clr_count",     count, 32'd0);
      chk("clr_pc",        pc, 32'd0);
      chk("clr_presetn",   proc_resetn, 32'd0);

      // start wins over same-cycle wr_en
      write_word(16'h1111);
      start   = 1'b1;
      wr_en   = 1'b1;
      wr_data = 16'h2222;
      step();
      start   = 1'b0;
      wr_en   = 1'b0;
      chk("prio_count",    count, 32'd1);
      chk("prio_iin",      iin, 32'h1111);
      chk("prio_busy",     busy, 32'd1);
      pulse_clear();

      // overflow: 17 writes, last one dropped
      for (int i = 0; i < DEPTH + 1; i++) write_word(16'h1000 + 16'(i));
      chk("ovf_count",     count, 32'd16);
      chk("ovf_full",      full, 32'd1);
      pulse_start();
      chk("ovf_iin0",      iin, 32'h1000);
      for (int i = 1; i < DEPTH; i++) done_pulse(16'(i));
      chk("ovf_pc15",      pc, 32'd15);
      chk("ovf_iin15",     iin, 32'h100F);
      done_pulse(16'hBEEF);
      chk("ovf_halted",    halted, 32'd1);
      chk("ovf_pcmax",     pc, 32'd15);
      chk("ovf_last",      last_result, 32'hBEEF);

      // clear then start on an empty buffer
      pulse_clear();
      pulse_start();
      chk("empty_halted",  halted, 32'd1);
      chk("empty_valid",   iin_valid, 32'd0);
      step();
      chk("empty_valid2",  iin_valid, 32'd0);
      chk("empty_count",   count, 32'd0);

      // async reset between edges while in WAIT
      pulse_clear();
      write_word(16'h3333);
      pulse_start();
      chk("ar_busy",       busy, 32'd1);
      #2;
      resetn = 1'b0;
      #1;
      chk("ar_iin",        iin, 32'h0);
      chk("ar_flags",      {iin_valid, busy, halted, error, proc_resetn}, 32'b0);
      chk("ar_count",      count, 32'd0);
      chk("ar_last",       last_result, 32'h0);
      step();
      resetn = 1'b1;

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Drives the 16-bit instruction word into the processor core, i.e. the producer end of the core's `iin`/`resetn` interface.
- Holds a small program buffer that is loaded word-by-word while idle. On `start` it issues the program one instruction at a time.
- Advances only on the core's completion pulse and captures the core's bus output at each completion.
- Flags a hung instruction with a cycle timeout.
- Sits between the testbench/host and the processor core.

Parameters:
- DEPTH, 16, number of program words in the buffer (power of two).
- AW, 4, address/pointer width; log2(DEPTH).
- TIMEOUT, 8, maximum cycles allowed in WAIT for `proc_done` per instruction (≥2).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `resetn`  in  1  asynchronous active-low reset.
- `wr_en`  in  1  append `wr_data` to the program buffer (IDLE only).
- `wr_data`  in  16  instruction word. Opcode in [15:13], X field [12:10], Y field [9:7], immediate in [6:0].
- `start`  in  1  single-cycle pulse; begin program execution.
- `clear`  in  1  single-cycle pulse; abort and empty the buffer.
- `proc_done`  in  1  core pulse: the current instruction has completed.
- `proc_out`  in  16  core bus output, sampled on `proc_done`.
- `iin`  out  16  instruction word to the core.
- `iin_valid`  out  1  `iin` holds a live instruction.
- `proc_resetn`  out  1  active-low reset to the core.
- `pc`  out  AW  index of the instruction currently issued.
- `count`  out  AW+1  number of words loaded (0..DEPTH).
- `last_result`  out  16  `proc_out` captured at the most recent `proc_done`.
- `busy`  out  1  high in WAIT.
- `halted`  out  1  high in HALT.
- `error`  out  1  high in ERROR.
- `full`  out  1  `count == DEPTH`.

Behaviour:
- Reset (async, `resetn` = 0) puts the block in IDLE with:
  - `count` = 0, `pc` = 0, `iin` = 16'h0000, `last_result` = 16'h0000;
  - `iin_valid` = 0, `busy` = 0, `halted` = 0, `error` = 0, `proc_resetn` = 0.
  - Buffer contents are don't-care.
- Registered outputs: all outputs are registered. `full` is decoded from registered `count`.
- `proc_resetn` is 0 in IDLE, HALT and ERROR, and 1 only in WAIT. The core is held cleared whenever nothing is issued.
- Input priority in every state: `clear` > `start` > `wr_en`.
- `clear` (any state): next state IDLE; `count` = 0, `pc` = 0, `iin_valid` = 0, all status flags 0.
- IDLE, load:
  - `wr_en` with `count` < DEPTH: `mem[count]` <= `wr_data`, `count`++.
  - `wr_en` with `count` == DEPTH: write dropped, `count` unchanged.
- IDLE, `start` (same-cycle `wr_en` ignored):
  - `count` == 0: go to HALT, `halted` = 1, nothing issued.
  - `count` > 0: `pc` = 0, `iin` <= `mem[0]`, `iin_valid` = 1, timer = 0, go to WAIT. `iin` is valid the cycle after `start`.
- WAIT: timer increments every cycle without `proc_done`.
  - `proc_done` and `pc` < `count`-1: `last_result` <= `proc_out`; `pc`++; `iin` <= `mem[pc+1]` (visible next cycle, 1-cycle issue latency); timer = 0.
  - `proc_done` and `pc` == `count`-1: `last_result` <= `proc_out`; go to HALT; `iin_valid` = 0; `iin` keeps its last value.
  - No `proc_done` and timer == TIMEOUT-1: go to ERROR; `iin_valid` = 0; `pc` frozen at the hung instruction.
  - `proc_done` wins over timeout in the same cycle.
  - `wr_en` and `start` are ignored in WAIT.
- HALT / ERROR:
  - `start` re-runs the same program from `pc` = 0 (same as `start` from IDLE with `count` > 0) and clears `halted`/`error`.
  - `wr_en` is ignored.
- `proc_done` outside WAIT is ignored; `last_result` does not update.
- `pc` never exceeds `count`-1; no wrap-around.
- `count` reaches DEPTH exactly; its width is AW+1.

Test Plan:
- Reset then load 3 words:
  - Stimulus: reset, then `wr_en` with 16'h2080, 16'h4100, 16'h0000.
  - Required: `count` = 3, `iin_valid` = 0, `proc_resetn` = 0, `full` = 0.
- Normal run:
  - Stimulus: pulse `start`; `proc_done` 3 cycles after each issue, with `proc_out` = 5, 9, 14.
  - Required: `iin` sequence 16'h2080 → 16'h4100 → 16'h0000, each valid 1 cycle after `start`/`proc_done`.
  - Required at end: `halted` = 1, `last_result` = 14, `pc` = 2, `proc_resetn` = 0.
- Timeout:
  - Stimulus: TIMEOUT = 8, `start`, never assert `proc_done`.
  - Required: `error` = 1 exactly 8 cycles after `iin_valid` rises; `pc` = 0; `iin_valid` = 0.
  - Then `start` again: required `error` = 0, `iin` = `mem[0]`.
- Overflow and empty start:
  - Stimulus: 17 writes with DEPTH = 16.
  - Required: `count` = 16, `full` = 1, 17th word not stored.
  - Stimulus: `clear` then `start`. Required: `halted` = 1 next cycle, `iin_valid` never 1.
- Priority and abort:
  - Stimulus: `start` + `wr_en` in the same IDLE cycle. Required: `count` unchanged.
  - Stimulus: `clear` during WAIT. Required: IDLE next cycle, `count` = 0, `proc_resetn` = 0.
  - Stimulus: `proc_done` coinciding with the timeout cycle. Required: advance, no `error`.
- Async reset mid-run:
  - Stimulus: drop `resetn` between clock edges in WAIT.
  - Required: outputs go to their reset values immediately, without waiting for a clock edge.
